// File: rtl/uop_debounce2.sv
// Two-channel switch conditioner: 2-flop synchroniser plus a stability filter
// per channel. The outputs are the clean levels x/y and a one-cycle change strobe
// for each channel.
module uop_debounce2 #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic sw_a,
    input  logic sw_b,
    output logic x,
    output logic y,
    output logic x_chg,
    output logic y_chg
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdleLo,
        StWaitHi,
        StIdleHi,
        StWaitLo
    } state_t;

    logic [1:0] sw_raw;
    logic [1:0] lvl;
    logic [1:0] chg;

    assign sw_raw = {sw_b, sw_a};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic          sync1_q, sync_q;
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          lvl_q, lvl_d;
        logic          chg_q, chg_d;

        // Two-flop synchroniser; only sync_q is visible to the filter.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                sync1_q <= 1'b0;
                sync_q  <= 1'b0;
            end else begin
                sync1_q <= sw_raw[ch];
                sync_q  <= sync1_q;
            end
        end

        // State register, stability counter and the registered outputs.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state_q <= StIdleLo;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                chg_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                chg_q   <= chg_d;
            end
        end

        // Next state and counter: count consecutive samples at the opposite level.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            unique case (state_q)
                StIdleLo: begin
                    if (sync_q) begin
                        state_d = StWaitHi;
                        cnt_d   = CW'(1);
                    end
                end
                StWaitHi: begin
                    if (!sync_q) begin
                        state_d = StIdleLo;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StIdleHi;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StIdleHi: begin
                    if (!sync_q) begin
                        state_d = StWaitLo;
                        cnt_d   = CW'(1);
                    end
                end
                StWaitLo: begin
                    if (sync_q) begin
                        state_d = StIdleHi;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StIdleLo;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = StIdleLo;
                end
            endcase
        end

        // Next output values: flip the level and strobe only on acceptance.
        always_comb begin
            lvl_d = lvl_q;
            chg_d = 1'b0;
            unique case (state_q)
                StWaitHi: begin
                    if (sync_q && cnt_q == CNT_LAST) begin
                        lvl_d = 1'b1;
                        chg_d = 1'b1;
                    end
                end
                StWaitLo: begin
                    if (!sync_q && cnt_q == CNT_LAST) begin
                        lvl_d = 1'b0;
                        chg_d = 1'b1;
                    end
                end
                default: begin
                    lvl_d = lvl_q;
                end
            endcase
        end

        assign lvl[ch] = lvl_q;
        assign chg[ch] = chg_q;
    end

    assign x     = lvl[0];
    assign y     = lvl[1];
    assign x_chg = chg[0];
    assign y_chg = chg[1];

endmodule

// File: tb/tb_uop_debounce2.sv
// Self-checking bench for uop_debounce2: directed scenarios plus randomised
// bouncing inputs, compared against a run-length reference model.
module tb_uop_debounce2;

    localparam int SC = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic sw_a, sw_b;
    logic x, y, x_chg, y_chg;

    int n_cmp = 0;
    int n_err = 0;
    int n_xchg = 0;
    int n_xhigh = 0;

    // Reference model: sync pipeline plus count of consecutive samples differing from the level.
    logic [1:0] m_s1, m_s, m_x, m_chg;
    int         m_run [2];

    uop_debounce2 #(.STABLE_CYCLES(SC)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .sw_a  (sw_a),
        .sw_b  (sw_b),
        .x     (x),
        .y     (y),
        .x_chg (x_chg),
        .y_chg (y_chg)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0;
        m_s  = '0;
        m_x  = '0;
        m_chg = '0;
        m_run[0] = 0;
        m_run[1] = 0;
    endtask

    task automatic model_step();
        logic [1:0] raw;
        raw = {sw_b, sw_a};
        if (RESET) begin
            model_reset();
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                m_chg[ch] = 1'b0;
                if (m_s[ch] != m_x[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == SC) begin
                        m_x[ch]   = ~m_x[ch];
                        m_chg[ch] = 1'b1;
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_s  = m_s1;
            m_s1 = raw;
        end
    endtask

    // One clock edge: advance the model, then sample the DUT just after the edge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_eq("x", x, m_x[0]);
        check_eq("y", y, m_x[1]);
        check_eq("x_chg", x_chg, m_chg[0]);
        check_eq("y_chg", y_chg, m_chg[1]);
        if (x_chg) n_xchg++;
        if (x) n_xhigh++;
    endtask

    task automatic settle(input logic a, input logic b);
        sw_a = a;
        sw_b = b;
        repeat (SC + 8) tick();
    endtask

    // Edges until the selected output reaches lvl; 99 if it never does within the budget.
    task automatic edges_until(input int ch, input logic lvl, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 20) begin
            tick();
            n++;
            hit = ((ch == 0) ? x : y) === lvl;
        end
        if (!hit) n = 99;
    endtask

    task automatic async_reset_pulse(input string tag);
        RESET = 1'b1;
        #1;
        check_eq({tag, "_x"}, x, 0);
        check_eq({tag, "_y"}, y, 0);
        check_eq({tag, "_xchg"}, x_chg, 0);
        check_eq({tag, "_ychg"}, y_chg, 0);
        model_reset();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        int n;
        int hold_a, hold_b;

        RESET = 1'b1;
        sw_a  = 1'b0;
        sw_b  = 1'b0;
        model_reset();
        repeat (2) tick();
        RESET = 1'b0;

        // Reset with both inputs high clears outputs before the next edge.
        settle(1'b1, 1'b1);
        check_eq("pre_rst_x", x, 1);
        async_reset_pulse("rst");
        n_xchg = 0;
        edges_until(0, 1'b1, n);
        check_eq("rst_release_lat", n, SC + 2);
        check_eq("rst_release_y", y, 1);
        repeat (4) tick();
        check_eq("rst_release_pulses", n_xchg, 1);

        // Clean press and release on channel A only.
        settle(1'b0, 1'b0);
        sw_a = 1'b1;
        edges_until(0, 1'b1, n);
        check_eq("press_lat", n, SC + 2);
        check_eq("press_strobe", x_chg, 1);
        check_eq("press_y", y, 0);
        sw_a = 1'b0;
        edges_until(0, 1'b0, n);
        check_eq("release_lat", n, SC + 2);
        check_eq("release_strobe", x_chg, 1);

        // Bounce 1,0,1,0 with 2-cycle phases, then settle high.
        settle(1'b0, 1'b0);
        n_xchg = 0;
        for (int i = 0; i < 4; i++) begin
            sw_a = (i % 2 == 0);
            repeat (2) tick();
        end
        check_eq("bounce_no_chg", n_xchg, 0);
        sw_a = 1'b1;
        edges_until(0, 1'b1, n);
        check_eq("bounce_lat", n, SC + 2);
        repeat (4) tick();
        check_eq("bounce_pulses", n_xchg, 1);

        // Width boundary: SC-1 cycle pulse rejected, SC cycle pulse accepted.
        settle(1'b0, 1'b0);
        n_xchg = 0;
        n_xhigh = 0;
        sw_a = 1'b1;
        repeat (SC - 1) tick();
        sw_a = 1'b0;
        repeat (12) tick();
        check_eq("short_pulse_chg", n_xchg, 0);
        check_eq("short_pulse_high", n_xhigh, 0);
        sw_a = 1'b1;
        repeat (SC) tick();
        sw_a = 1'b0;
        repeat (14) tick();
        check_eq("min_pulse_chg", n_xchg, 2);
        check_eq("min_pulse_high", n_xhigh, SC);

        // Simultaneous rise on both channels.
        settle(1'b0, 1'b0);
        sw_a = 1'b1;
        sw_b = 1'b1;
        edges_until(0, 1'b1, n);
        check_eq("simul_lat", n, SC + 2);
        check_eq("simul_y", y, 1);
        check_eq("simul_xchg", x_chg, 1);
        check_eq("simul_ychg", y_chg, 1);

        // Reset mid-count discards progress.
        settle(1'b0, 1'b0);
        sw_a = 1'b1;
        repeat (4) tick();
        check_eq("midcnt_x", x, 0);
        async_reset_pulse("midrst");
        edges_until(0, 1'b1, n);
        check_eq("midrst_lat", n, SC + 2);

        // Randomised bouncing inputs with occasional resets.
        hold_a = 0;
        hold_b = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_a == 0) begin
                sw_a   = $urandom_range(1, 0);
                hold_a = $urandom_range(SC + 3, 1);
            end
            if (hold_b == 0) begin
                sw_b   = $urandom_range(1, 0);
                hold_b = $urandom_range(SC + 3, 1);
            end
            hold_a--;
            hold_b--;
            if ($urandom_range(399, 0) == 0) begin
                async_reset_pulse("rand_rst");
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uop_debounce2.md
Name: uop_debounce2

Overview:
- Two-channel switch conditioner that sits directly upstream of the 2-input AND/NAND gate stage.
- Takes raw, bouncing, asynchronous push-button/slide-switch levels, synchronises them to CLK and filters bounce.
- Presents clean levels x and y for the gate inputs, plus a one-cycle change strobe per channel for later counter/FSM tasks.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised samples at a new level needed to accept it. Legal range ≥2. Use 4 for simulation; 500000 gives a 10 ms filter at 50 MHz.
- CW, $clog2(STABLE_CYCLES+1), stability counter width. Derived; do not override.

Ports:
- CLK  input  1  system clock, rising-edge active
- RESET  input  1  asynchronous, active-high reset
- sw_a  input  1  raw switch A, asynchronous to CLK, may bounce
- sw_b  input  1  raw switch B, asynchronous to CLK, may bounce
- x  output  1  debounced level of sw_a; drives gate input x
- y  output  1  debounced level of sw_b; drives gate input y
- x_chg  output  1  one-cycle strobe when x changes value (either direction)
- y_chg  output  1  one-cycle strobe when y changes value (either direction)

Behaviour:
- Interface: one clock, CLK. Reset is asynchronous and active-high on RESET.
- Reset state, applied immediately while RESET=1: x=0, y=0, x_chg=0, y_chg=0, synchroniser flops=0, counters=0, both FSMs in IDLE_LO.
- Channels are identical and fully independent. Channel A is described; B mirrors it (sw_b→y→y_chg).
- Synchroniser: two flops, sw_a→s1→s. Only s feeds the filter; raw sw_a never reaches logic directly.
- FSM, 4 states, all transitions evaluated on the rising edge of CLK:
  - IDLE_LO (x=0): s=1 → WAIT_HI, cnt=1. Otherwise stay, cnt=0.
  - WAIT_HI (x=0):
    - s=0 → IDLE_LO, cnt=0. Bounce rejected; x unchanged, no strobe.
    - s=1 and cnt=STABLE_CYCLES-1 → IDLE_HI, x←1, x_chg←1.
    - s=1 otherwise → cnt+1.
  - IDLE_HI (x=1): s=0 → WAIT_LO, cnt=1. Otherwise stay.
  - WAIT_LO (x=1):
    - s=1 → IDLE_HI, cnt=0.
    - s=0 and cnt=STABLE_CYCLES-1 → IDLE_LO, x←0, x_chg←1.
    - s=0 otherwise → cnt+1.
- Latency: raw change sampled at edge 1 → s changes after edge 2 → x changes after edge 2+STABLE_CYCLES (edge 6 at default). Minimum accepted pulse width at s = STABLE_CYCLES cycles.
- x and x_chg are registered outputs; no combinational path from sw_a.
- x_chg is high for exactly one cycle, the first cycle x shows its new value. It is never asserted two cycles in a row.
- Counter never exceeds STABLE_CYCLES-1 and never wraps.
- Both channels may strobe in the same cycle; no arbitration.
- RESET mid-count (any WAIT state) discards the count. Outputs are 0 even if x was 1. After release, a held-high input needs the full 2+STABLE_CYCLES edges to reassert x.
- A constant-high input at reset release is treated as a fresh rise: x_chg pulses when x goes to 1.

Test Plan:
- Reset check: assert RESET with sw_a=sw_b=1 → x=y=x_chg=y_chg=0 asynchronously, before the next CLK edge. Release → x=1 after edge 6 with a single x_chg pulse.
- Clean press, STABLE_CYCLES=4: sw_a 0→1 held → x=1 after edge 6, x_chg=1 for exactly that cycle, y and y_chg stay 0. Release sw_a → x=0 after edge 6, one x_chg pulse.
- Bounce rejection: sw_a toggles 1,0,1,0 with 2-cycle phases, then settles high → no x change during bounce. x=1 exactly 6 edges after the final rise; only one x_chg.
- Width boundary: clean sw_a pulse of 3 cycles → x stays 0, no strobe. Pulse of 4 cycles → x=1 for 4 cycles; x_chg on rise and on fall.
- Simultaneous channels: sw_a and sw_b rise on the same edge → x, y, x_chg, y_chg all assert in the same cycle. Gate downstream sees z=1 from that cycle.
- Reset mid-count: sw_a rises, RESET asserted after edge 4 for 1 cycle → x remains 0. After release, x=1 exactly 6 edges after release, not earlier.
